parity_gen_chk: RTL and testbench
=================================

# parity_gen_chk

Parametrised, registered parity generator and checker for WIDTH-bit words, with a runtime even/odd mode. The generate path accepts data words over a valid/ready handshake and emits {parity, data} words one cycle later. The check path receives {parity, data} words and reports a registered per-word error pulse, a sticky error flag and a saturating error counter. It supersedes the fixed 8-bit combinational even-parity generator used between the data sources and the serial/link layer.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (>= 1)
- CNT_W, 8, error counter width in bits (>= 1)

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- odd  input  1  parity mode: 0 = even, 1 = odd; sampled with each accepted word on either path
- in_valid  input  1  generate path: input word valid
- in_ready  output  1  generate path: block can accept a word this cycle
- in_data  input  WIDTH  generate path: data word
- out_valid  output  1  generate path: output word valid
- out_ready  input  1  generate path: downstream accepts this cycle
- out_data  output  WIDTH+1  generate path: {parity, data}; parity bit is the MSB
- chk_valid  input  1  check path: word present (no backpressure; always accepted)
- chk_data  input  WIDTH+1  check path: {parity, data}
- chk_err  output  1  one-cycle pulse: the previous cycle's checked word failed
- err_sticky  output  1  set by any failure, held until cnt_clr
- err_cnt  output  CNT_W  saturating count of failed words
- cnt_clr  input  1  synchronous clear of err_cnt and err_sticky

## Operation
- Parity rule: p = ^in_data when odd=0; p = ~^in_data when odd=1. Therefore {p, data} contains an even (odd=0) or odd (odd=1) number of ones.
- Generate path: one-entry output register.
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer in: in_valid && in_ready. The block loads out_data = {p, in_data} and sets out_valid = 1.
  - Transfer out: out_valid && out_ready. If no new word loads in the same cycle, out_valid clears.
  - Simultaneous transfer in and out: the new word replaces the old one and out_valid stays 1. Full throughput is one word per cycle.
  - While out_valid && !out_ready, out_data and out_valid hold stable. in_ready = 0, and in_data is ignored.
- Check path:
  - A word fails when chk_valid = 1 and (^chk_data) != odd, i.e. the ones-count parity of the whole WIDTH+1-bit word does not match the mode.
  - On a failure, chk_err pulses for exactly one cycle, err_sticky sets, and err_cnt increments.
  - err_cnt saturates at 2^CNT_W-1 and never wraps.
  - chk_valid = 0 means no check takes place and chk_err = 0.
- cnt_clr has priority over a simultaneous failure. err_cnt becomes 0 and err_sticky becomes 0, but chk_err still pulses for that failure.
- The two paths are independent and may be active in the same cycle. odd applies to both paths in that cycle.

## Timing
- Reset values (asynchronous on rst_n = 0): out_valid = 0, out_data = 0, chk_err = 0, err_sticky = 0, err_cnt = 0. in_ready = 1 as soon as reset asserts.
- Reset mid-operation: a word held in the output register is discarded, and a pending chk_err pulse is dropped. The first edge after release behaves as from idle.
- Generate latency: a word accepted at edge N appears on out_data with out_valid = 1 after edge N.
- Check latency: a word presented at edge N produces chk_err, err_sticky and err_cnt updates visible after edge N.
- All outputs except in_ready are registered. in_ready depends only on out_valid and out_ready.

## Test plan
- WIDTH=8, odd=0, in_data=0x07, out_ready=1 -> out_data=0x107 one cycle later. With odd=1 -> 0x007. in_data=0x00, odd=1 -> 0x100.
- Backpressure: hold out_ready=0, send 0x5A then 0x3C -> out_data stays 0x05A and in_ready=0 until out_ready=1. Then 0x03C follows with no loss or duplication. Back-to-back streaming with out_ready=1 gives one word per cycle.
- Check: odd=0, chk_data=0x103 -> chk_err pulse, err_sticky=1, err_cnt=1. chk_data=0x107 -> no error. odd=1, chk_data=0x007 -> no error.
- Saturation: CNT_W=2, seven consecutive failing words -> err_cnt reads 1,2,3,3,3,3,3. cnt_clr coincident with a failure -> err_cnt=0 and err_sticky=0, with chk_err still 1.
- Reset mid-operation: with out_valid=1 and err_cnt=2, pulse rst_n low asynchronously -> all outputs go immediately to their reset values. The next accepted word is generated correctly.
- Loopback: random in_data and odd over 1000 words, out_data fed to chk_data with the same odd -> err_cnt remains 0. Flipping any single bit -> exactly one chk_err per flipped word.

Source files
------------

// File: rtl/parity_gen_chk.sv
// Registered parity generator (one-entry valid/ready output stage) and
// parity checker with error pulse, sticky flag and saturating error counter.
module parity_gen_chk #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             odd,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  input  logic             chk_valid,
  input  logic [WIDTH:0]   chk_data,
  output logic             chk_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr
);

  localparam int unsigned OUT_W = WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             chk_err_q, chk_err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic gen_par_c;
  logic in_xfer_c;
  logic chk_fail_c;

  // Even mode: parity equals XOR of data; odd mode inverts it.
  assign gen_par_c  = (^in_data) ^ odd;
  assign in_ready   = !out_valid_q || out_ready;
  assign in_xfer_c  = in_valid && in_ready;
  assign chk_fail_c = chk_valid && ((^chk_data) != odd);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    chk_err_d    = chk_fail_c;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;

    if (in_xfer_c) begin
      out_valid_d = 1'b1;
      out_data_d  = {gen_par_c, in_data};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear wins over a coincident failure; the pulse itself still fires.
    if (cnt_clr) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end else if (chk_fail_c) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      chk_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      chk_err_q    <= chk_err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign chk_err    = chk_err_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_parity_gen_chk.sv
// Directed bench for parity_gen_chk (WIDTH=8, CNT_W=2 so saturation is reachable).
module tb_parity_gen_chk;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             odd;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_data;
  logic             chk_valid;
  logic [WIDTH:0]   chk_data;
  logic             chk_err;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;
  logic             cnt_clr;

  int n_checks = 0;
  int n_fail   = 0;

  parity_gen_chk #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .odd        (odd),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .chk_valid  (chk_valid),
    .chk_data   (chk_data),
    .chk_err    (chk_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .cnt_clr    (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle 1ns past it; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'h000);
    check({tag, "_chk_err"},   32'(chk_err),   32'd0);
    check({tag, "_sticky"},    32'(err_sticky), 32'd0);
    check({tag, "_cnt"},       32'(err_cnt),   32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  logic [WIDTH-1:0] d;
  logic             o;
  logic [WIDTH:0]   word;
  logic             flip;
  logic [3:0]       sat_exp [7];

  initial begin
    rst_n = 1'b0; odd = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    chk_valid = 1'b0; chk_data = '0; cnt_clr = 1'b0;
    repeat (2) tick();
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Generate path, basic parity values
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h07; odd = 1'b0;
    tick();
    check("gen_even_07_valid", 32'(out_valid), 32'd1);
    check("gen_even_07", 32'(out_data), 32'h107);
    in_data = 8'h07; odd = 1'b1;
    tick();
    check("gen_odd_07", 32'(out_data), 32'h007);
    in_data = 8'h00; odd = 1'b1;
    tick();
    check("gen_odd_00", 32'(out_data), 32'h100);
    in_valid = 1'b0;
    tick();
    check("gen_drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: 0x5A held, 0x3C waits, then follows exactly once
    odd = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    tick();
    check("bp_first_data", 32'(out_data), 32'h05A);
    check("bp_first_valid", 32'(out_valid), 32'd1);
    in_data = 8'h3C;
    #1;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (2) begin
      tick();
      check("bp_hold_data", 32'(out_data), 32'h05A);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", 32'(in_ready), 32'd1);
    tick();
    check("bp_second_data", 32'(out_data), 32'h03C);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // Back-to-back streaming, one word per cycle
    in_valid = 1'b1; in_data = 8'h01;
    tick();
    check("stream_01", 32'(out_data), 32'h101);
    in_data = 8'h03;
    tick();
    check("stream_03", 32'(out_data), 32'h003);
    in_data = 8'hFF;
    tick();
    check("stream_ff", 32'(out_data), 32'h0FF);
    check("stream_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();

    // Check path
    odd = 1'b0; chk_valid = 1'b1; chk_data = 9'h103;
    tick();
    check("chk_103_err", 32'(chk_err), 32'd1);
    check("chk_103_sticky", 32'(err_sticky), 32'd1);
    check("chk_103_cnt", 32'(err_cnt), 32'd1);
    chk_data = 9'h107;
    tick();
    check("chk_107_err", 32'(chk_err), 32'd0);
    check("chk_107_cnt", 32'(err_cnt), 32'd1);
    check("chk_107_sticky", 32'(err_sticky), 32'd1);
    odd = 1'b1; chk_data = 9'h007;
    tick();
    check("chk_odd_007_err", 32'(chk_err), 32'd0);
    chk_valid = 1'b0; chk_data = 9'h001;
    tick();
    check("chk_novalid_err", 32'(chk_err), 32'd0);
    check("chk_novalid_cnt", 32'(err_cnt), 32'd1);

    // Saturation with a 2-bit counter
    cnt_clr = 1'b1;
    tick();
    check("clr_cnt", 32'(err_cnt), 32'd0);
    check("clr_sticky", 32'(err_sticky), 32'd0);
    cnt_clr = 1'b0; odd = 1'b0; chk_valid = 1'b1; chk_data = 9'h001;
    sat_exp = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("sat_cnt_%0d", i), 32'(err_cnt), 32'(sat_exp[i]));
      check($sformatf("sat_err_%0d", i), 32'(chk_err), 32'd1);
    end
    cnt_clr = 1'b1;
    tick();
    check("clr_fail_cnt", 32'(err_cnt), 32'd0);
    check("clr_fail_sticky", 32'(err_sticky), 32'd0);
    check("clr_fail_err", 32'(chk_err), 32'd1);
    cnt_clr = 1'b0;

    // Reset mid-operation: held word, err_cnt=2, pending chk_err
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_cnt", 32'(err_cnt), 32'd2);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    chk_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    #1;
    rst_n = 1'b1;
    odd = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h07;
    tick();
    check("post_rst_data", 32'(out_data), 32'h107);
    check("post_rst_cnt", 32'(err_cnt), 32'd0);
    check("post_rst_err", 32'(chk_err), 32'd0);
    in_valid = 1'b0;
    tick();

    // Loopback: clean words then words with occasional single-bit flips
    for (int i = 0; i < 1000; i++) begin
      d = WIDTH'($urandom);
      o = 1'($urandom);
      odd = o; in_valid = 1'b1; in_data = d; chk_valid = 1'b0;
      tick();
      word = {(^d) ^ o, d};
      check($sformatf("lb_gen_%0d", i), 32'(out_data), 32'(word));
      flip = (i >= 500) && (($urandom & 1) == 1);
      in_valid = 1'b0; chk_valid = 1'b1;
      chk_data = out_data;
      if (flip) chk_data = chk_data ^ (9'd1 << $urandom_range(0, WIDTH));
      tick();
      check($sformatf("lb_chk_%0d", i), 32'(chk_err), 32'(flip));
      if (i == 499) check("lb_clean_cnt", 32'(err_cnt), 32'd0);
    end
    chk_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
